// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU logic units, the result stage and its consumer.
// The master side is the environment (upstream plus downstream); the slave side is the stage.
interface alu_result_stage_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [OPW-1:0]   in_op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_parity;
    logic             out_msb;
    logic [WIDTH-1:0] acc_out;
    logic [7:0]       dlv_cnt;

    modport master (
        output in_valid, in_data, in_op, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_op,
        input  out_zero, out_parity, out_msb, acc_out, dlv_cnt
    );

    modport slave (
        input  in_valid, in_data, in_op, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_op,
        output out_zero, out_parity, out_msb, acc_out, dlv_cnt
    );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: 2-entry skid FIFO with per-entry status flags,
// a running XOR checksum of accepted results and a delivered-result counter.
module alu_result_stage #(
    parameter int WIDTH = 8,
    parameter int OPW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_stage_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [OPW-1:0]   op;
        logic             zero;
        logic             parity;
        logic             msb;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;

    logic   in_ready;
    logic   out_valid;
    logic   push;
    logic   pop;
    entry_t new_e;

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        new_e.data   = bus.in_data;
        new_e.op     = bus.in_op;
        new_e.zero   = ~|bus.in_data;
        new_e.parity = ^bus.in_data;
        new_e.msb    = bus.in_data[WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_e;
                end else if (push) begin
                    tail_d  = new_e;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Clear takes effect before folding a same-cycle result.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (bus.acc_clr && push) begin
            acc_d = bus.in_data;
        end else if (bus.acc_clr) begin
            acc_d = '0;
        end else if (push) begin
            acc_d = acc_q ^ bus.in_data;
        end
        if (pop) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = head_q.data;
    assign bus.out_op     = head_q.op;
    assign bus.out_zero   = head_q.zero;
    assign bus.out_parity = head_q.parity;
    assign bus.out_msb    = head_q.msb;
    assign bus.acc_out    = acc_q;
    assign bus.dlv_cnt    = cnt_q;

endmodule
